// File: rtl/ifetch_bridge_pkg.sv
// ifetch_bridge_pkg: shared FSM states, kseg mask constants and bus constants for the fetch bridge
package ifetch_bridge_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RET} state_t;
  localparam logic [2:0] KSEG_SEG_MASK = 3'b110;
  localparam logic [2:0] KSEG_SEG_MATCH = 3'b100;
  localparam logic [1:0] INST_SIZE_WORD = 2'b10;
  localparam logic [31:0] PC_INITIAL = 32'hbfc00000;
endpackage

// File: rtl/ifetch_addr_map.sv
// ifetch_addr_map: strips kseg0/kseg1 segment bits to form the physical bus address
module ifetch_addr_map
  import ifetch_bridge_pkg::*;
#(
  parameter int KSEG_MAP = 1
) (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);
  logic kseg;
  assign kseg = (KSEG_MAP != 0) && ((vaddr[31:29] & KSEG_SEG_MASK) == KSEG_SEG_MATCH);
  assign paddr = kseg ? {3'b000, vaddr[28:0]} : vaddr;
endmodule

// File: rtl/ifetch_bridge.sv
// ifetch_bridge: single-outstanding instruction fetch bridge from PC stage to the bus
// Define IFETCH_ALIGN_CHECK_EN to fail misaligned fetches without touching the bus.
module ifetch_bridge
#(
  parameter int KSEG_MAP = 1,
  parameter logic [31:0] PC_INITIAL = ifetch_bridge_pkg::PC_INITIAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cache_call_begin,
  input  logic [31:0] IF_pc_out,
  output logic        cache_return_ready,
  output logic [31:0] IF_instruction,
  output logic        IF_fetch_error,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);
  import ifetch_bridge_pkg::*;
  state_t state, state_nx;
  logic [31:0] pc_q;
  logic err_q, misaligned, accept;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = IF_pc_out[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif
  assign accept = state == IDLE && cache_call_begin;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cache_call_begin) state_nx = misaligned ? RET : REQ;
      REQ: if (inst_addr_ok) state_nx = WAIT;
      WAIT: if (inst_data_ok) state_nx = RET;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_q <= PC_INITIAL;
      err_q <= 1'b0;
      IF_instruction <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        pc_q <= IF_pc_out;
        err_q <= misaligned;
        if (misaligned) IF_instruction <= '0;
      end
      if (state == WAIT && inst_data_ok) IF_instruction <= inst_rdata;
    end
  end
  ifetch_addr_map #(.KSEG_MAP(KSEG_MAP)) u_map (.vaddr(pc_q), .paddr(inst_addr));
  assign inst_req = state == REQ;
  assign cache_return_ready = state == RET;
  assign IF_fetch_error = err_q && state == RET;
  assign inst_wr = 1'b0;
  assign inst_size = INST_SIZE_WORD;
  assign inst_wdata = '0;
endmodule

// File: tb/tb_ifetch_bridge.sv
// tb_ifetch_bridge: directed fetches with queued expectations checked by bus and return monitors
module tb_ifetch_bridge;
  logic clk = 0, reset = 1;
  logic cache_call_begin = 0, inst_addr_ok = 0, inst_data_ok = 0;
  logic [31:0] IF_pc_out = '0, inst_rdata = '0;
  logic cache_return_ready, IF_fetch_error, inst_req, inst_wr;
  logic [1:0] inst_size;
  logic [31:0] IF_instruction, inst_addr, inst_wdata;
  int errors = 0, checks = 0, txns = 0;
  logic [32:0] exp_ret[$];
  logic [31:0] exp_addr[$];
  logic [31:0] last_inst = '0, cur_addr = '0;
  logic req_prev = 0;

  ifetch_bridge dut (
    .clk(clk), .reset(reset), .cache_call_begin(cache_call_begin), .IF_pc_out(IF_pc_out),
    .cache_return_ready(cache_return_ready), .IF_instruction(IF_instruction),
    .IF_fetch_error(IF_fetch_error), .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // bus monitor: each new request pops its expected address, held until the request ends
  always @(negedge clk) begin
    if (reset) req_prev = 0;
    else begin
      if (inst_req) begin
        if (!req_prev) begin
          if (exp_addr.size() == 0) chk("unexpected_req", 32'(inst_req), 0);
          else cur_addr = exp_addr.pop_front();
        end
        chk("inst_addr", inst_addr, cur_addr);
        chk("inst_wr", 32'(inst_wr), 0);
        chk("inst_size", 32'(inst_size), 2);
        chk("inst_wdata", inst_wdata, 0);
        if (inst_addr_ok) txns++;
      end
      req_prev = inst_req;
    end
  end

  // return monitor: every ready pulse must match the oldest queued response
  always @(negedge clk) begin
    if (!reset && cache_return_ready) begin
      if (exp_ret.size() == 0) chk("unexpected_ready", 32'(cache_return_ready), 0);
      else begin
        logic [32:0] e;
        e = exp_ret.pop_front();
        chk("ret_inst", IF_instruction, e[31:0]);
        chk("ret_err", 32'(IF_fetch_error), 32'(e[32]));
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, rd, ea, input int ad, dd, input bit stray);
    exp_addr.push_back(ea);
    exp_ret.push_back({1'b0, rd});
    cache_call_begin = 1; IF_pc_out = pc; tick;
    cache_call_begin = 0; IF_pc_out = '0;
    chk("req_asserted", 32'(inst_req), 1);
    chk("inst_hold", IF_instruction, last_inst);
    inst_data_ok = ad > 0; inst_rdata = 32'hdeadbeef;
    repeat (ad) tick;
    inst_data_ok = 0; inst_addr_ok = 1; tick; inst_addr_ok = 0;
    chk("req_dropped", 32'(inst_req), 0);
    cache_call_begin = stray; IF_pc_out = 32'h12345678;
    repeat (dd) tick;
    inst_data_ok = 1; inst_rdata = rd; tick; inst_data_ok = 0;
    chk("ready_latency", 32'(cache_return_ready), 1);
    tick; cache_call_begin = 0;
    chk("ready_single", 32'(cache_return_ready), 0);
    chk("idle_after_ret", 32'(inst_req), 0);
    last_inst = rd;
  endtask

  initial begin
    int t0;
    tick; tick;
    chk("rst_ready", 32'(cache_return_ready), 0);
    chk("rst_req", 32'(inst_req), 0);
    chk("rst_err", 32'(IF_fetch_error), 0);
    chk("rst_inst", IF_instruction, 0);
    chk("rst_addr", inst_addr, 32'h1fc00000);
    reset = 0; tick;
    fetch(32'hbfc00000, 32'h3c1d0000, 32'h1fc00000, 0, 0, 0);
    fetch(32'h80001000, 32'h11111111, 32'h00001000, 4, 0, 0);
    t0 = txns;
    fetch(32'hc0000000, 32'h22222222, 32'hc0000000, 1, 2, 1);
    chk("one_txn", txns - t0, 1);
    fetch(32'ha0000004, 32'h33333333, 32'h00000004, 0, 1, 0);
    fetch(32'h00400000, 32'h44444444, 32'h00400000, 2, 0, 0);
    inst_data_ok = 1; inst_rdata = 32'hbad0bad0; tick; inst_data_ok = 0;
    chk("idle_data_ignored", 32'(cache_return_ready), 0);
    chk("idle_inst_hold", IF_instruction, 32'h44444444);
    exp_addr.push_back(32'h1fc00010);
    cache_call_begin = 1; IF_pc_out = 32'hbfc00010; tick; cache_call_begin = 0;
    inst_addr_ok = 1; tick; inst_addr_ok = 0;
    reset = 1; tick; reset = 0;
    inst_data_ok = 1; inst_rdata = 32'h55555555; tick; inst_data_ok = 0;
    chk("abandon_ready", 32'(cache_return_ready), 0);
    chk("abandon_inst", IF_instruction, 0);
    tick;
    chk("abandon_idle", 32'(inst_req), 0);
    last_inst = '0;
    fetch(32'hbfc00100, 32'h66666666, 32'h1fc00100, 0, 0, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
    exp_ret.push_back({1'b1, 32'h0});
    cache_call_begin = 1; IF_pc_out = 32'hbfc00002; tick; cache_call_begin = 0;
    chk("misalign_noreq", 32'(inst_req), 0);
    chk("misalign_ready", 32'(cache_return_ready), 1);
    chk("misalign_err", 32'(IF_fetch_error), 1);
    chk("misalign_inst", IF_instruction, 0);
    tick;
    chk("misalign_single", 32'(cache_return_ready), 0);
`endif
    tick; tick;
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("ret_queue_empty", exp_ret.size(), 0);
    chk("txn_total", txns, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifetch_bridge.md
IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

Interface
REQ-001 SHALL have parameter KSEG_MAP, default 1, meaning 1 enables kseg0/kseg1 virtual-to-physical mapping on the bus address.
REQ-002 SHALL have parameter PC_INITIAL, default 32'hbfc00000, meaning the reset value of the held fetch address.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- cache_call_begin  in  1  one-cycle fetch request pulse from the PC stage.
- IF_pc_out  in  32  fetch address, valid in the cycle cache_call_begin is high.
- cache_return_ready  out  1  one-cycle pulse: instruction available.
- IF_instruction  out  32  fetched instruction, held until the next return.
- IF_fetch_error  out  1  error flag, qualified by cache_return_ready.
- inst_req  out  1  bus request.
- inst_wr  out  1  bus write, tied 0.
- inst_size  out  2  bus size, tied 2'b10 (word).
- inst_addr  out  32  bus physical address.
- inst_wdata  out  32  bus write data, tied 0.
- inst_addr_ok  in  1  bus address accepted.
- inst_data_ok  in  1  bus read data valid.
- inst_rdata  in  32  bus read data.

Function
REQ-004 SHALL implement the FSM states IDLE, REQ, WAIT, and RET.
REQ-005 In IDLE, cache_call_begin=1 SHALL latch IF_pc_out, go to REQ, and assert inst_req from the next cycle.
REQ-006 In REQ, inst_req and inst_addr SHALL stay stable until inst_addr_ok=1 is sampled; the FSM SHALL then go to WAIT and deassert inst_req in the following cycle.
REQ-007 In WAIT, inst_data_ok=1 SHALL latch inst_rdata into IF_instruction and go to RET.
- inst_data_ok seen in IDLE or REQ SHALL be ignored.
REQ-008 In RET, the FSM SHALL assert cache_return_ready for exactly one cycle and then return to IDLE.
REQ-009 Minimum latency SHALL be 3 cycles: call at t, inst_req at t+1, addr_ok at t+1, data_ok at t+2, ready at t+3.
REQ-010 cache_call_begin outside IDLE (including in RET) SHALL be ignored; the latched address SHALL NOT change.
REQ-011 With KSEG_MAP=1, address bits [31:29] of 3'b100 or 3'b101 SHALL be forced to 3'b000; all other addresses SHALL pass unchanged.
- With KSEG_MAP=0, addresses SHALL pass unchanged.
REQ-012 IF_instruction SHALL hold its value when not in RET, including across new requests, until the next latch.
REQ-013 At most one bus transaction SHALL be outstanding; inst_req SHALL never be asserted in WAIT or RET.

Reset
REQ-014 Reset SHALL set the following values.
- FSM state: IDLE.
- inst_req: 0.
- cache_return_ready: 0.
- IF_fetch_error: 0.
- IF_instruction: 32'h0.
- Latched address: PC_INITIAL.
REQ-015 Reset during REQ or WAIT SHALL abandon the transaction, and a later inst_data_ok SHALL be ignored in IDLE.
- Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-016 Macro IFETCH_ALIGN_CHECK_EN, when defined, SHALL enable the misaligned-address check.
- With the macro defined: a request with IF_pc_out[1:0]!=0 SHALL issue no bus request and go IDLE->RET directly, with IF_fetch_error=1 and IF_instruction=32'h0 in the RET cycle.
- With the macro defined: IF_fetch_error SHALL be 0 on aligned returns.
- Without the macro: no check SHALL be made, IF_fetch_error SHALL be constant 0, and the address SHALL be issued as is.

Structure
REQ-017 A shared package SHALL hold the FSM state enum, the KSEG mask constants, and the INST_SIZE_WORD constant.
- PC_INITIAL in that package SHALL match the PC stage value.
REQ-018 Address mapping SHALL be one combinational sub-module, ifetch_addr_map; there SHALL be no other sub-modules.

Verification
REQ-019 Reset, then call with pc=32'hbfc00000 and addr_ok the same cycle as req -> inst_addr=32'h1fc00000; data_ok at t+2 with rdata=32'h3c1d0000 -> ready pulse at t+3 with IF_instruction=32'h3c1d0000.
REQ-020 addr_ok held low 4 cycles -> inst_req and inst_addr stable all 4 cycles; exactly one ready pulse after data_ok.
REQ-021 Second cache_call_begin during WAIT -> ignored; one bus transaction total; inst_addr unchanged.
REQ-022 Reset asserted in WAIT, then a stray data_ok -> no ready pulse and IF_instruction=0.
REQ-023 KSEG_MAP=1 with pc=32'h80001000 -> inst_addr=32'h00001000; pc=32'hc0000000 -> inst_addr=32'hc0000000.
REQ-024 IFETCH_ALIGN_CHECK_EN defined, pc=32'hbfc00002 -> no inst_req; ready one cycle after call with IF_fetch_error=1 and IF_instruction=0.
